pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_seq_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 31 +++
 rtl/pll_lock_sequencer.sv | 156 +++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pll_seq_pkg
// Description : Shared state encoding and field widths for the PLL lock
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_seq_pkg;

    localparam int c_STATE_W = 3;
    localparam int c_LOSS_W  = 8;

    typedef enum logic [c_STATE_W-1:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single asynchronous level.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_lock_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pll_lock_sequencer
// Description : Brings up a PLL from the board reference clock, proves lock
//               stability, then releases the PLL-domain system reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 3
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                locked,
    input  logic                soft_reset_req,
    output logic                pll_rst,
    output logic                sys_rst,
    output logic                fail,
    output logic [c_STATE_W-1:0] state_o,
    output logic [c_LOSS_W-1:0]  lock_loss_count
);

    localparam int c_MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int c_CNT_MAX = (c_MAX_AB > LOCK_TIMEOUT_CYCLES) ? c_MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam int c_RETRY_W = (MAX_RETRIES > 1) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [c_CNT_W-1:0]   c_RST_LAST     = c_CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_STABLE_LAST  = c_CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0]   c_TIMEOUT_LAST = c_CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_RETRY_W-1:0] c_MAX_RETRY    = c_RETRY_W'(MAX_RETRIES);

    pll_state_t           r_state;
    pll_state_t           w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [c_RETRY_W-1:0] r_retry;
    logic [c_RETRY_W-1:0] w_retry_nxt;
    logic [c_RETRY_W-1:0] w_retry_inc;
    logic [c_LOSS_W-1:0]  r_loss;
    logic [c_LOSS_W-1:0]  w_loss_nxt;
    logic                 r_pll_rst;
    logic                 r_sys_rst;
    logic                 r_fail;
    logic                 w_locked_s;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .i_d (locked),
        .o_q (w_locked_s)
    );

    assign w_retry_inc = r_retry + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_retry_nxt = r_retry;
        w_loss_nxt  = r_loss;

        // A lock drop in RUN is counted even when a soft reset lands on the same cycle.
        if (r_state == ST_RUN && !w_locked_s && r_loss != '1) begin
            w_loss_nxt = r_loss + 1'b1;
        end

        if (soft_reset_req) begin
            w_state_nxt = ST_PLL_RESET;
            w_cnt_nxt   = '0;
            w_retry_nxt = '0;
        end else begin
            unique case (r_state)
                ST_PLL_RESET: begin
                    if (r_cnt == c_RST_LAST) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_locked_s) begin
                        w_state_nxt = ST_STABILIZE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_TIMEOUT_LAST) begin
                        w_retry_nxt = w_retry_inc;
                        w_cnt_nxt   = '0;
                        w_state_nxt = (w_retry_inc == c_MAX_RETRY) ? ST_FAIL : ST_PLL_RESET;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_STABILIZE: begin
                    if (!w_locked_s) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_STABLE_LAST) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = '0;
                        w_retry_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!w_locked_s) begin
                        w_state_nxt = ST_PLL_RESET;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_FAIL: begin
                    w_cnt_nxt = '0;
                end
                default: begin
                    w_state_nxt = ST_PLL_RESET;
                    w_cnt_nxt   = '0;
                    w_retry_nxt = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they move on the same edge as state_o.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_PLL_RESET;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_loss    <= '0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_fail    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_retry   <= w_retry_nxt;
            r_loss    <= w_loss_nxt;
            r_pll_rst <= (w_state_nxt == ST_PLL_RESET);
            r_sys_rst <= (w_state_nxt != ST_RUN);
            r_fail    <= (w_state_nxt == ST_FAIL);
        end
    end

    assign pll_rst         = r_pll_rst;
    assign sys_rst         = r_sys_rst;
    assign fail            = r_fail;
    assign state_o         = r_state;
    assign lock_loss_count = r_loss;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_sequencer
// Description : Self-checking bench: directed vector table, corner sequences
//               and random lock activity against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_sequencer;

    localparam int P_RST     = 4;
    localparam int P_STABLE  = 8;
    localparam int P_TIMEOUT = 32;
    localparam int P_RETRIES = 2;

    localparam int S_PR   = 0;
    localparam int S_WAIT = 1;
    localparam int S_STAB = 2;
    localparam int S_RUN  = 3;
    localparam int S_FAIL = 4;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       soft_reset_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       fail;
    logic [2:0] state_o;
    logic [7:0] lock_loss_count;

    int n_checks = 0;
    int n_errors = 0;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_STABLE_CYCLES  (P_STABLE),
        .LOCK_TIMEOUT_CYCLES (P_TIMEOUT),
        .MAX_RETRIES         (P_RETRIES)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .locked          (locked),
        .soft_reset_req  (soft_reset_req),
        .pll_rst         (pll_rst),
        .sys_rst         (sys_rst),
        .fail            (fail),
        .state_o         (state_o),
        .lock_loss_count (lock_loss_count)
    );

    always #5 refclk = ~refclk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: lock is seen two samples late, each phase has a dwell limit.
    int m_st;
    int m_age;
    int m_tries;
    int m_loss;
    bit m_hist[$];

    task automatic m_reset();
        m_st = S_PR; m_age = 0; m_tries = 0; m_loss = 0;
        m_hist = '{1'b0, 1'b0};
    endtask

    task automatic m_enter(input int s);
        m_st = s; m_age = 0;
    endtask

    task automatic m_step(input bit lk, input bit sr);
        bit seen;
        seen = m_hist[1];
        m_hist.push_front(lk);
        void'(m_hist.pop_back());
        if (m_st == S_RUN && !seen) m_loss = (m_loss < 255) ? m_loss + 1 : 255;
        if (sr) begin
            m_enter(S_PR); m_tries = 0;
        end else if (m_st == S_PR) begin
            if (m_age + 1 == P_RST) m_enter(S_WAIT); else m_age++;
        end else if (m_st == S_WAIT) begin
            if (seen) m_enter(S_STAB);
            else if (m_age + 1 == P_TIMEOUT) begin
                m_tries++;
                m_enter((m_tries == P_RETRIES) ? S_FAIL : S_PR);
            end else m_age++;
        end else if (m_st == S_STAB) begin
            if (!seen) m_enter(S_WAIT);
            else if (m_age + 1 == P_STABLE) begin m_enter(S_RUN); m_tries = 0; end
            else m_age++;
        end else if (m_st == S_RUN) begin
            if (!seen) m_enter(S_PR);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".state"},   int'(state_o), m_st);
        chk({tag, ".pll_rst"}, int'(pll_rst), (m_st == S_PR) ? 1 : 0);
        chk({tag, ".sys_rst"}, int'(sys_rst), (m_st == S_RUN) ? 0 : 1);
        chk({tag, ".fail"},    int'(fail),    (m_st == S_FAIL) ? 1 : 0);
        chk({tag, ".loss"},    int'(lock_loss_count), m_loss);
    endtask

    // Drive at the falling edge, let the rising edge act, observe 1 ns later.
    task automatic tick(input bit lk, input bit sr);
        @(negedge refclk);
        locked = lk;
        soft_reset_req = sr;
        @(posedge refclk);
        m_step(lk, sr);
        #1;
    endtask

    task automatic wait_state(input int s, input string tag);
        int k;
        k = 0;
        while (int'(state_o) != s && k < 64) begin
            tick(1'b1, 1'b0);
            check_model(tag);
            k++;
        end
        chk({tag, ".reached"}, int'(state_o), s);
    endtask

    typedef struct {
        bit lk;
        bit sr;
        int reps;
        int st;
        bit prst;
        bit srst;
        bit fl;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit lk, input bit sr, input int reps, input int st);
        vec_t v;
        v.lk = lk; v.sr = sr; v.reps = reps; v.st = st;
        v.prst = (st == S_PR);
        v.srst = (st != S_RUN);
        v.fl   = (st == S_FAIL);
        vecs.push_back(v);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit r_lvl;
        bit r_sr;
        int r_len;
        int cyc;
        int exp_loss;

        m_reset();

        // Bring-up: locked rises 10 cycles after pll_rst falls, RUN 10 edges later.
        add(0, 0, 3,  S_PR);
        add(0, 0, 10, S_WAIT);
        add(1, 0, 2,  S_WAIT);
        add(1, 0, 8,  S_STAB);
        add(1, 0, 2,  S_RUN);
        // One-cycle lock glitch at STABILIZE cycle 5 restarts the stable count.
        add(1, 1, 1,  S_PR);
        add(1, 0, 3,  S_PR);
        add(1, 0, 1,  S_WAIT);
        add(1, 0, 5,  S_STAB);
        add(0, 0, 1,  S_STAB);
        add(1, 0, 1,  S_STAB);
        add(1, 0, 1,  S_WAIT);
        add(1, 0, 8,  S_STAB);
        add(1, 0, 2,  S_RUN);
        // No lock at all: two timeouts then FAIL; soft reset recovers.
        add(0, 1, 1,  S_PR);
        add(0, 0, 3,  S_PR);
        add(0, 0, 32, S_WAIT);
        add(0, 0, 4,  S_PR);
        add(0, 0, 32, S_WAIT);
        add(0, 0, 5,  S_FAIL);
        add(0, 1, 1,  S_PR);
        add(1, 0, 3,  S_PR);
        add(1, 0, 1,  S_WAIT);
        add(1, 0, 8,  S_STAB);
        add(1, 0, 2,  S_RUN);

        repeat (3) @(posedge refclk);
        #1;
        chk("reset.state",   int'(state_o), S_PR);
        chk("reset.pll_rst", int'(pll_rst), 1);
        chk("reset.sys_rst", int'(sys_rst), 1);
        chk("reset.fail",    int'(fail), 0);
        chk("reset.loss",    int'(lock_loss_count), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                tick(vecs[i].lk, vecs[i].sr);
                chk($sformatf("vec%0d.%0d.state", i, r),   int'(state_o), vecs[i].st);
                chk($sformatf("vec%0d.%0d.pll_rst", i, r), int'(pll_rst), int'(vecs[i].prst));
                chk($sformatf("vec%0d.%0d.sys_rst", i, r), int'(sys_rst), int'(vecs[i].srst));
                chk($sformatf("vec%0d.%0d.fail", i, r),    int'(fail),    int'(vecs[i].fl));
            end
        end
        chk("table.loss", int'(lock_loss_count), 0);

        // Soft reset and synchronized lock drop on the same cycle in RUN.
        tick(1'b0, 1'b0);
        chk("simul.d0.state", int'(state_o), S_RUN);
        tick(1'b1, 1'b0);
        chk("simul.d1.state", int'(state_o), S_RUN);
        tick(1'b1, 1'b1);
        chk("simul.state",   int'(state_o), S_PR);
        chk("simul.sys_rst", int'(sys_rst), 1);
        chk("simul.pll_rst", int'(pll_rst), 1);
        chk("simul.loss",    int'(lock_loss_count), 1);
        check_model("simul");

        // 300 lock losses in RUN: the count saturates at 255.
        for (int i = 1; i <= 300; i++) begin
            wait_state(S_RUN, "loss_relock");
            tick(1'b0, 1'b0);
            check_model("loss_drop");
            tick(1'b1, 1'b0);
            check_model("loss_drop");
            tick(1'b1, 1'b0);
            exp_loss = (i + 1 > 255) ? 255 : i + 1;
            chk($sformatf("loss_sat.%0d", i), int'(lock_loss_count), exp_loss);
            chk($sformatf("loss_sat.%0d.state", i), int'(state_o), S_PR);
        end
        chk("loss_final", int'(lock_loss_count), 255);

        // Asynchronous reset in the middle of a STABILIZE cycle.
        tick(1'b1, 1'b1);
        check_model("pre_async");
        wait_state(S_STAB, "to_stab");
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        chk("pre_async.state", int'(state_o), S_STAB);
        #2;
        rst = 1'b1;
        #1;
        chk("async.state",   int'(state_o), S_PR);
        chk("async.pll_rst", int'(pll_rst), 1);
        chk("async.sys_rst", int'(sys_rst), 1);
        chk("async.fail",    int'(fail), 0);
        chk("async.loss",    int'(lock_loss_count), 0);
        @(posedge refclk);
        #1;
        rst = 1'b0;
        m_reset();

        // Random lock activity with occasional soft resets.
        cyc = 0;
        while (cyc < 3000) begin
            r_lvl = ($urandom_range(0, 99) < 70);
            r_len = $urandom_range(1, 80);
            for (int j = 0; j < r_len; j++) begin
                r_sr = ($urandom_range(0, 199) == 0);
                tick(r_lvl, r_sr);
                check_model("rand");
                cyc++;
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
